// File: rtl/sw_debounce.sv
// Switch debouncer: 2-flop synchronizer, shared sample-tick prescaler and a
// per-bit run-length qualifier that accepts a new level after STABLE_SAMPLES ticks.
module sw_debounce #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TICK_DIV       = 50000,
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_sw_raw,
    output logic [DATA_WIDTH-1:0] o_io_sw,
    output logic                  o_sw_changed,
    output logic                  o_tick
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

    logic [DATA_WIDTH-1:0] sync1_q;
    logic [DATA_WIDTH-1:0] sync2_q;

    logic [PRE_W-1:0]      pre_q;
    logic [PRE_W-1:0]      pre_d;
    logic                  tick_q;
    logic                  tick_d;

    logic [CNT_W-1:0]      cnt_q [DATA_WIDTH];
    logic [CNT_W-1:0]      cnt_d [DATA_WIDTH];
    logic [DATA_WIDTH-1:0] sw_q;
    logic [DATA_WIDTH-1:0] sw_d;
    logic                  chg_q;
    logic                  chg_d;

    // Metastability guard: nothing downstream sees i_sw_raw directly.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= i_sw_raw;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler; the registered strobe marks the cycle whose closing edge samples.
    always_comb begin
        pre_d  = pre_q + PRE_W'(1);
        tick_d = 1'b0;
        if (pre_q == PRE_LAST) begin
            pre_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    // Any tick that sees the current level restarts that bit's qualification.
    always_comb begin
        sw_d = sw_q;
        for (int unsigned b = 0; b < DATA_WIDTH; b++) begin
            cnt_d[b] = cnt_q[b];
            if (tick_q) begin
                if (sync2_q[b] == sw_q[b]) begin
                    cnt_d[b] = '0;
                end else if (cnt_q[b] == CNT_LAST) begin
                    sw_d[b]  = sync2_q[b];
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end
        end
        chg_d = (sw_d != sw_q);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '{default: '0};
            sw_q  <= '0;
            chg_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sw_q  <= sw_d;
            chg_q <= chg_d;
        end
    end

    assign o_io_sw      = sw_q;
    assign o_sw_changed = chg_q;
    assign o_tick       = tick_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: directed scenarios plus random switch activity, all
// checked against a run-length reference model of the sampling rules.
module tb_sw_debounce;

    localparam int unsigned DW = 32;
    localparam int unsigned TD = 4;
    localparam int unsigned SS = 3;

    logic          i_clk;
    logic          i_reset;
    logic [DW-1:0] i_sw_raw;
    logic [DW-1:0] o_io_sw;
    logic          o_sw_changed;
    logic          o_tick;

    int checks = 0;
    int errors = 0;

    sw_debounce #(
        .DATA_WIDTH    (DW),
        .TICK_DIV      (TD),
        .STABLE_SAMPLES(SS)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_sw_raw    (i_sw_raw),
        .o_io_sw     (o_io_sw),
        .o_sw_changed(o_sw_changed),
        .o_tick      (o_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model: raw levels reach the qualifier two edges late; edges are
    // counted from reset release; the strobe is visible after every TD-th edge
    // and the following edge samples.
    logic [DW-1:0] hist[$];
    logic [DW-1:0] m_sw;
    logic [DW-1:0] m_prev;
    logic [DW-1:0] m_samp;
    int            run_len[DW];
    int unsigned   n_edge;
    logic          m_tick;
    logic          m_chg;

    initial begin : model
        m_sw   = '0;
        m_tick = 1'b0;
        m_chg  = 1'b0;
        n_edge = 0;
        foreach (run_len[k]) run_len[k] = 0;
        forever begin
            @(posedge i_clk or posedge i_reset);
            if (i_reset) begin
                hist.delete();
                m_sw   = '0;
                m_tick = 1'b0;
                m_chg  = 1'b0;
                n_edge = 0;
                foreach (run_len[k]) run_len[k] = 0;
            end else begin
                m_samp = (hist.size() == 2) ? hist[0] : '0;
                m_prev = m_sw;
                n_edge++;
                if (n_edge > 1 && (n_edge - 1) % TD == 0) begin
                    for (int b = 0; b < DW; b++) begin
                        if (m_samp[b] != m_prev[b]) begin
                            run_len[b]++;
                            if (run_len[b] == SS) begin
                                m_sw[b]    = m_samp[b];
                                run_len[b] = 0;
                            end
                        end else begin
                            run_len[b] = 0;
                        end
                    end
                end
                m_chg  = (m_sw != m_prev);
                m_tick = (n_edge % TD == 0);
                hist.push_back(i_sw_raw);
                if (hist.size() > 2) void'(hist.pop_front());
            end
        end
    end

    task automatic test_reset();
        i_reset  = 1'b1;
        i_sw_raw = '0;
        repeat (3) begin
            @(negedge i_clk);
            checks++;
            if (o_io_sw !== '0) begin
                errors++;
                $display("FAIL reset_sw: got %h expected 0", o_io_sw);
            end
            checks++;
            if (o_tick !== 1'b0 || o_sw_changed !== 1'b0) begin
                errors++;
                $display("FAIL reset_strobes: tick=%b chg=%b expected 0/0", o_tick, o_sw_changed);
            end
        end
    endtask

    task automatic test_tick_cadence();
        logic exp_tick;
        i_reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            exp_tick = (i % 4 == 0);
            checks++;
            if (o_tick !== exp_tick) begin
                errors++;
                $display("FAIL tick_cadence: cycle %0d got %b expected %b", i, o_tick, exp_tick);
            end
            checks++;
            if (o_tick !== m_tick) begin
                errors++;
                $display("FAIL tick_model: cycle %0d got %b model %b", i, o_tick, m_tick);
            end
            checks++;
            if (o_io_sw !== '0) begin
                errors++;
                $display("FAIL tick_sw_idle: cycle %0d got %h expected 0", i, o_io_sw);
            end
        end
    endtask

    task automatic test_clean_press();
        int rise_at = 0;
        int pulses  = 0;
        i_sw_raw = 32'h0000_0001;
        for (int i = 21; i <= 40; i++) begin
            @(negedge i_clk);
            if (o_sw_changed === 1'b1) pulses++;
            if (rise_at == 0 && o_io_sw[0] === 1'b1) rise_at = i;
            checks++;
            if (o_io_sw !== m_sw || o_sw_changed !== m_chg) begin
                errors++;
                $display("FAIL press_model: cycle %0d got %h/%b model %h/%b", i, o_io_sw, o_sw_changed, m_sw, m_chg);
            end
        end
        checks++;
        if (rise_at != 33) begin
            errors++;
            $display("FAIL press_latency: accepted at cycle %0d expected 33", rise_at);
        end
        checks++;
        if (pulses != 1 || o_io_sw !== 32'h0000_0001) begin
            errors++;
            $display("FAIL press_pulse: pulses=%0d sw=%h expected 1 / 00000001", pulses, o_io_sw);
        end
    endtask

    task automatic test_release();
        int pulses = 0;
        i_sw_raw = '0;
        repeat (24) begin
            @(negedge i_clk);
            if (o_sw_changed === 1'b1) pulses++;
            checks++;
            if (o_io_sw !== m_sw || o_sw_changed !== m_chg) begin
                errors++;
                $display("FAIL release_model: got %h/%b model %h/%b", o_io_sw, o_sw_changed, m_sw, m_chg);
            end
        end
        checks++;
        if (pulses != 1 || o_io_sw !== '0) begin
            errors++;
            $display("FAIL release_end: pulses=%0d sw=%h expected 1 / 0", pulses, o_io_sw);
        end
    endtask

    task automatic test_bounce();
        int guard  = 0;
        int pulses = 0;
        int rise_at = 0;
        while (o_tick !== 1'b1 && guard < 16) begin
            @(negedge i_clk);
            guard++;
        end
        checks++;
        if (o_tick !== 1'b1) begin
            errors++;
            $display("FAIL bounce_align: tick not seen within %0d cycles", guard);
        end
        i_sw_raw[3] = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(negedge i_clk);
            if (o_sw_changed === 1'b1) pulses++;
            if (rise_at == 0 && o_io_sw[3] === 1'b1) rise_at = i;
            checks++;
            if (o_io_sw !== m_sw || o_sw_changed !== m_chg) begin
                errors++;
                $display("FAIL bounce_model: cycle %0d got %h/%b model %h/%b", i, o_io_sw, o_sw_changed, m_sw, m_chg);
            end
            if (i == 4) i_sw_raw[3] = 1'b0;
            if (i == 8) i_sw_raw[3] = 1'b1;
        end
        checks++;
        if (rise_at != 21) begin
            errors++;
            $display("FAIL bounce_latency: accepted at cycle %0d expected 21", rise_at);
        end
        checks++;
        if (pulses != 1 || o_io_sw !== 32'h0000_0008) begin
            errors++;
            $display("FAIL bounce_end: pulses=%0d sw=%h expected 1 / 00000008", pulses, o_io_sw);
        end
    endtask

    task automatic test_simultaneous();
        int   pulses  = 0;
        logic partial = 1'b0;
        i_sw_raw = '0;
        repeat (24) @(negedge i_clk);
        checks++;
        if (o_io_sw !== '0) begin
            errors++;
            $display("FAIL simul_clear: got %h expected 0", o_io_sw);
        end
        i_sw_raw = 32'hFFFF_0000;
        repeat (24) begin
            @(negedge i_clk);
            if (o_sw_changed === 1'b1) pulses++;
            if (o_io_sw !== '0 && o_io_sw !== 32'hFFFF_0000) partial = 1'b1;
            checks++;
            if (o_io_sw !== m_sw || o_sw_changed !== m_chg) begin
                errors++;
                $display("FAIL simul_model: got %h/%b model %h/%b", o_io_sw, o_sw_changed, m_sw, m_chg);
            end
        end
        checks++;
        if (pulses != 1 || partial || o_io_sw !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL simul_end: pulses=%0d partial=%b sw=%h expected 1 / 0 / ffff0000", pulses, partial, o_io_sw);
        end
    endtask

    task automatic test_reset_mid();
        int guard   = 0;
        int pulses  = 0;
        int rise_at = 0;
        while (o_tick !== 1'b1 && guard < 16) begin
            @(negedge i_clk);
            guard++;
        end
        i_sw_raw = 32'hFFFF_0001;
        repeat (10) @(negedge i_clk);
        checks++;
        if (o_io_sw !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL mid_before: got %h expected ffff0000", o_io_sw);
        end
        #2;
        i_reset = 1'b1;
        #1;
        checks++;
        if (o_io_sw !== '0 || o_sw_changed !== 1'b0 || o_tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: sw=%h chg=%b tick=%b expected all 0", o_io_sw, o_sw_changed, o_tick);
        end
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_clk);
            if (o_sw_changed === 1'b1) pulses++;
            if (rise_at == 0 && o_io_sw[0] === 1'b1) rise_at = i;
            checks++;
            if (o_io_sw !== m_sw || o_sw_changed !== m_chg || o_tick !== m_tick) begin
                errors++;
                $display("FAIL mid_model: cycle %0d got %h/%b/%b model %h/%b/%b",
                         i, o_io_sw, o_sw_changed, o_tick, m_sw, m_chg, m_tick);
            end
        end
        checks++;
        if (rise_at != 13 || pulses != 1 || o_io_sw !== 32'hFFFF_0001) begin
            errors++;
            $display("FAIL mid_requalify: rise=%0d pulses=%0d sw=%h expected 13 / 1 / ffff0001", rise_at, pulses, o_io_sw);
        end
    endtask

    task automatic test_random();
        int unsigned odds;
        for (int i = 0; i < 1500; i++) begin
            odds = ((i / 100) % 2 == 1) ? 4 : 40;
            if ($urandom_range(odds - 1, 0) == 0) begin
                i_sw_raw = i_sw_raw ^ (DW'(1) << $urandom_range(7, 0));
                if ($urandom_range(3, 0) == 0) i_sw_raw = i_sw_raw ^ DW'($urandom_range(255, 0));
            end
            @(negedge i_clk);
            checks++;
            if (o_io_sw !== m_sw || o_sw_changed !== m_chg || o_tick !== m_tick) begin
                errors++;
                $display("FAIL random_model: cycle %0d got %h/%b/%b model %h/%b/%b",
                         i, o_io_sw, o_sw_changed, o_tick, m_sw, m_chg, m_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_tick_cadence();
        test_clean_press();
        test_release();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
